// File: rtl/mmio_ctrl.sv
// Memory-mapped UART bridge and performance counters, sitting beside dmem with 1-cycle read latency.
// Define MMIO_BRANCH_STATS_EN to build the branch and taken-branch counters at 0x1C/0x20.
module mmio_ctrl #(
    parameter logic [3:0]  MMIO_BASE = 4'h8,
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_en,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retire,
    input  logic        br_valid,
    input  logic        br_taken,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    typedef logic [CTR_WIDTH-1:0] ctr_t;

    localparam logic [7:0] AddrStatus   = 8'h00;
    localparam logic [7:0] AddrRx       = 8'h04;
    localparam logic [7:0] AddrTx       = 8'h08;
    localparam logic [7:0] AddrCycle    = 8'h10;
    localparam logic [7:0] AddrInst     = 8'h14;
    localparam logic [7:0] AddrClear    = 8'h18;
    localparam logic [7:0] AddrBr       = 8'h1C;
    localparam logic [7:0] AddrBrTaken  = 8'h20;

    logic        access, rd_req, wr_req;
    logic [7:0]  offset;
    logic        tx_wr, ctr_clear;

    logic [31:0] rdata_q, rdata_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        overrun_q, overrun_d;
    ctr_t        cycle_cnt_q, cycle_cnt_d;
    ctr_t        inst_cnt_q, inst_cnt_d;
    logic [31:0] br_word, br_taken_word;

    assign access    = mmio_en && (mmio_addr[31:28] == MMIO_BASE);
    assign rd_req    = access && (mmio_we == 4'h0);
    assign wr_req    = access && (mmio_we != 4'h0);
    assign offset    = {mmio_addr[7:2], 2'b00};
    assign tx_wr     = wr_req && (offset == AddrTx);
    assign ctr_clear = wr_req && (offset == AddrClear);

    assign mmio_rdata    = rdata_q;
    assign uart_tx_valid = tx_full_q;
    assign uart_tx_data  = tx_byte_q;
    assign uart_rx_ready = ~rx_full_q;

    // Only byte-lane 0 of store data and addr[7:2] participate in decode.
    logic unused_bits;
    assign unused_bits = ^{mmio_addr[27:8], mmio_addr[1:0], mmio_wdata[31:8]};

`ifdef MMIO_BRANCH_STATS_EN
    ctr_t br_cnt_q, br_cnt_d;
    ctr_t br_taken_cnt_q, br_taken_cnt_d;

    always_comb begin
        br_cnt_d       = br_cnt_q + ctr_t'(br_valid);
        br_taken_cnt_d = br_taken_cnt_q + ctr_t'(br_valid && br_taken);
        if (ctr_clear) begin
            br_cnt_d       = '0;
            br_taken_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else begin
            br_cnt_q       <= br_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    assign br_word       = 32'(br_cnt_q);
    assign br_taken_word = 32'(br_taken_cnt_q);
`else
    logic unused_br;
    assign unused_br     = br_valid ^ br_taken;
    assign br_word       = 32'h0;
    assign br_taken_word = 32'h0;
`endif

    always_comb begin
        rdata_d     = rdata_q;
        tx_full_d   = tx_full_q;
        tx_byte_d   = tx_byte_q;
        rx_full_d   = rx_full_q;
        rx_byte_d   = rx_byte_q;
        overrun_d   = overrun_q;
        cycle_cnt_d = cycle_cnt_q + ctr_t'(1);
        inst_cnt_d  = inst_cnt_q + ctr_t'(inst_retire);

        if (rd_req) begin
            case (offset)
                AddrStatus:  rdata_d = {29'd0, overrun_q, rx_full_q, ~tx_full_q};
                AddrRx:      rdata_d = rx_full_q ? {24'd0, rx_byte_q} : 32'h0;
                AddrCycle:   rdata_d = 32'(cycle_cnt_q);
                AddrInst:    rdata_d = 32'(inst_cnt_q);
                AddrBr:      rdata_d = br_word;
                AddrBrTaken: rdata_d = br_taken_word;
                default:     rdata_d = 32'h0;
            endcase
            if (offset == AddrStatus) overrun_d = 1'b0;
            if (offset == AddrRx)     rx_full_d = 1'b0;
        end

        if (tx_full_q && uart_tx_ready) tx_full_d = 1'b0;

        // A store into a full holding register is lost even if the UART drains it this cycle.
        if (tx_wr) begin
            if (tx_full_q) begin
                overrun_d = 1'b1;
            end else begin
                tx_full_d = 1'b1;
                tx_byte_d = mmio_wdata[7:0];
            end
        end

        if (uart_rx_valid && !rx_full_q) begin
            rx_full_d = 1'b1;
            rx_byte_d = uart_rx_data;
        end

        if (ctr_clear) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q     <= 32'h0;
            tx_full_q   <= 1'b0;
            tx_byte_q   <= 8'h0;
            rx_full_q   <= 1'b0;
            rx_byte_q   <= 8'h0;
            overrun_q   <= 1'b0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            rdata_q     <= rdata_d;
            tx_full_q   <= tx_full_d;
            tx_byte_q   <= tx_byte_d;
            rx_full_q   <= rx_full_d;
            rx_byte_q   <= rx_byte_d;
            overrun_q   <= overrun_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of the register map, UART holding registers and counters.
module tb_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_en;
    logic [3:0]  mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        inst_retire, br_valid, br_taken;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_ready;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    mmio_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_en       (mmio_en),
        .mmio_we       (mmio_we),
        .mmio_addr     (mmio_addr),
        .mmio_wdata    (mmio_wdata),
        .mmio_rdata    (mmio_rdata),
        .inst_retire   (inst_retire),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    // Reference model: state updated once per clock from the register-map rules.
    logic [31:0] m_rdata, m_cycle, m_inst, m_br, m_brt;
    logic        m_tx_full, m_rx_full, m_overrun;
    logic [7:0]  m_tx_byte, m_rx_byte;

    always @(posedge clk or negedge rst) begin : model
        logic       acc, rd, wr, old_tx, old_rx, clr;
        logic [7:0] off;
        if (!rst) begin
            m_rdata = 0; m_cycle = 0; m_inst = 0; m_br = 0; m_brt = 0;
            m_tx_full = 0; m_rx_full = 0; m_overrun = 0; m_tx_byte = 0; m_rx_byte = 0;
        end else begin
            acc    = mmio_en && (mmio_addr[31:28] == 4'h8);
            rd     = acc && (mmio_we == 4'h0);
            wr     = acc && (mmio_we != 4'h0);
            off    = mmio_addr[7:0] & 8'hFC;
            old_tx = m_tx_full;
            old_rx = m_rx_full;
            if (rd) begin
                case (off)
                    8'h00: m_rdata = {29'd0, m_overrun, m_rx_full, !m_tx_full};
                    8'h04: m_rdata = m_rx_full ? {24'd0, m_rx_byte} : 32'd0;
                    8'h10: m_rdata = m_cycle;
                    8'h14: m_rdata = m_inst;
`ifdef MMIO_BRANCH_STATS_EN
                    8'h1C: m_rdata = m_br;
                    8'h20: m_rdata = m_brt;
`endif
                    default: m_rdata = 0;
                endcase
                if (off == 8'h00) m_overrun = 0;
                if (off == 8'h04) m_rx_full = 0;
            end
            if (old_tx && uart_tx_ready) m_tx_full = 0;
            if (wr && off == 8'h08) begin
                if (old_tx) m_overrun = 1;
                else begin
                    m_tx_full = 1;
                    m_tx_byte = mmio_wdata[7:0];
                end
            end
            if (uart_rx_valid && !old_rx) begin
                m_rx_full = 1;
                m_rx_byte = uart_rx_data;
            end
            clr     = wr && off == 8'h18;
            m_cycle = clr ? 0 : m_cycle + 1;
            m_inst  = clr ? 0 : m_inst + (inst_retire ? 1 : 0);
            m_br    = clr ? 0 : m_br + (br_valid ? 1 : 0);
            m_brt   = clr ? 0 : m_brt + ((br_valid && br_taken) ? 1 : 0);
        end
    end

    task automatic idle_inputs();
        mmio_en = 0; mmio_we = 0; mmio_addr = 0; mmio_wdata = 0;
        inst_retire = 0; br_valid = 0; br_taken = 0;
        uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 0;
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        mmio_en = 1; mmio_we = 4'h0; mmio_addr = a;
        @(negedge clk);
        d = mmio_rdata;
        mmio_en = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] v);
        mmio_en = 1; mmio_we = 4'hF; mmio_addr = a; mmio_wdata = v;
        @(negedge clk);
        mmio_en = 0; mmio_we = 4'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        idle_inputs();
        rst = 0;
        #1;
        n_checks++;
        if (mmio_rdata !== 32'h0 || uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: rdata=%h tx_valid=%b rx_ready=%b want 0/0/1",
                     mmio_rdata, uart_tx_valid, uart_rx_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (10) @(negedge clk);
        do_read(32'h8000_0010, d);
        n_checks++;
        if (d !== 32'd10) begin
            n_bad++; $display("FAIL reset_cycle_cnt: got %0d want 10", d);
        end
        do_read(32'h8000_0000, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_bad++; $display("FAIL reset_status: got %h want 00000001", d);
        end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        uart_tx_ready = 0;
        do_write(32'h8000_0008, 32'h41);
        do_write(32'h8000_0008, 32'h42);
        n_checks++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
            n_bad++;
            $display("FAIL tx_hold: valid=%b data=%h want 1/41", uart_tx_valid, uart_tx_data);
        end
        do_read(32'h8000_0000, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_bad++; $display("FAIL tx_overrun_status: got %h want 00000004", d);
        end
        do_read(32'h8000_0000, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL tx_overrun_clear: got %h want 00000000", d);
        end
        uart_tx_ready = 1;
        @(negedge clk);
        uart_tx_ready = 0;
        n_checks++;
        if (uart_tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL tx_drain: valid=%b want 0", uart_tx_valid);
        end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        uart_rx_data = 8'h5A; uart_rx_valid = 1;
        @(negedge clk);
        uart_rx_valid = 0; uart_rx_data = 8'h00;
        n_checks++;
        if (uart_rx_ready !== 1'b0) begin
            n_bad++; $display("FAIL rx_ready_fall: got %b want 0", uart_rx_ready);
        end
        do_read(32'h8000_0000, d);
        n_checks++;
        if (d !== 32'h3) begin
            n_bad++; $display("FAIL rx_status: got %h want 00000003", d);
        end
        do_read(32'h8000_0004, d);
        n_checks++;
        if (d !== 32'h5A) begin
            n_bad++; $display("FAIL rx_pop: got %h want 0000005a", d);
        end
        do_read(32'h8000_0006, d);
        n_checks++;
        if (d !== 32'h0 || uart_rx_ready !== 1'b1) begin
            n_bad++; $display("FAIL rx_empty: got %h ready=%b want 0/1", d, uart_rx_ready);
        end
    endtask

    task automatic test_counters();
        logic [31:0] d;
        do_write(32'h8000_0018, 32'h0);
        repeat (7) begin
            inst_retire = 1; @(negedge clk);
            inst_retire = 0; @(negedge clk);
        end
        do_read(32'h8000_0014, d);
        n_checks++;
        if (d !== 32'd7) begin
            n_bad++; $display("FAIL inst_count: got %0d want 7", d);
        end
        inst_retire = 1;
        do_write(32'h8000_0018, 32'hDEAD_BEEF);
        inst_retire = 0;
        do_read(32'h8000_0014, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_bad++; $display("FAIL clear_beats_inc: got %0d want 0", d);
        end
        // Preload the cycle counter to all-ones and watch it roll over.
        mmio_en = 1; mmio_we = 0; mmio_addr = 32'h8000_0010;
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt_q;
        @(negedge clk);
        mmio_en = 0;
        n_checks++;
        if (mmio_rdata !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL cycle_preload: got %h want ffffffff", mmio_rdata);
        end
        do_read(32'h8000_0010, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL cycle_wrap: got %h want 00000000", d);
        end
        do_write(32'h8000_0018, 32'h0);
    endtask

    task automatic test_branch();
        logic [31:0] d, want_br, want_brt;
`ifdef MMIO_BRANCH_STATS_EN
        want_br = 4; want_brt = 3;
`else
        want_br = 0; want_brt = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            br_valid = 1; br_taken = (i != 2);
            @(negedge clk);
            br_valid = 0; br_taken = (i == 2);
            @(negedge clk);
        end
        br_taken = 0;
        do_read(32'h8000_001C, d);
        n_checks++;
        if (d !== want_br) begin
            n_bad++; $display("FAIL br_cnt: got %0d want %0d", d, want_br);
        end
        do_read(32'h8000_0020, d);
        n_checks++;
        if (d !== want_brt) begin
            n_bad++; $display("FAIL br_taken_cnt: got %0d want %0d", d, want_brt);
        end
    endtask

    task automatic test_random();
        logic [7:0] offs [10];
        offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h0C, 8'h44};
        for (int i = 0; i < 400; i++) begin
            mmio_en     = ($urandom_range(0, 9) < 7);
            mmio_we     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (mmio_we != 0 && $urandom_range(0, 3) != 0) mmio_we = (i % 5 == 0) ? mmio_we : 4'h0;
            mmio_addr   = $urandom;
            mmio_addr[31:28] = ($urandom_range(0, 9) < 9) ? 4'h8 : 4'($urandom_range(0, 15));
            mmio_addr[7:0]   = offs[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
            mmio_wdata    = $urandom;
            inst_retire   = $urandom_range(0, 1) == 1;
            br_valid      = $urandom_range(0, 1) == 1;
            br_taken      = $urandom_range(0, 1) == 1;
            uart_tx_ready = $urandom_range(0, 3) == 0;
            uart_rx_valid = $urandom_range(0, 2) == 0;
            uart_rx_data  = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (mmio_rdata !== m_rdata) begin
                n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, mmio_rdata, m_rdata);
            end
            n_checks++;
            if (uart_tx_valid !== m_tx_full || (m_tx_full && uart_tx_data !== m_tx_byte)) begin
                n_bad++;
                $display("FAIL rand_tx[%0d]: valid=%b data=%h want %b/%h", i, uart_tx_valid,
                         uart_tx_data, m_tx_full, m_tx_byte);
            end
            n_checks++;
            if (uart_rx_ready !== !m_rx_full) begin
                n_bad++;
                $display("FAIL rand_rx_ready[%0d]: got %b want %b", i, uart_rx_ready, !m_rx_full);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        uart_tx_ready = 0;
        do_read(32'h8000_0004, d);
        do_write(32'h8000_0008, 32'h77);
        do_read(32'h8000_0010, d);
        n_checks++;
        if (uart_tx_valid !== 1'b1 || mmio_rdata === 32'h0) begin
            n_bad++;
            $display("FAIL pre_reset: valid=%b rdata=%h want 1/nonzero", uart_tx_valid, mmio_rdata);
        end
        #2 rst = 0;
        #1;
        n_checks++;
        if (uart_tx_valid !== 1'b0 || mmio_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b rdata=%h want 0/0", uart_tx_valid, mmio_rdata);
        end
        @(negedge clk);
        rst = 1;
        do_read(32'h8000_0000, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_bad++; $display("FAIL post_reset_status: got %h want 00000001", d);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_counters();
        test_branch();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
- Memory-mapped I/O controller downstream of the core's EX/MEM stage.
- Consumes the same address, store data and byte-enable stream that drives dmem whenever addr[31:28]==4'h8.
- Returns read data with the same 1-cycle latency as dmem, for the writeback mux.
- Bridges to the on-chip UART through 1-byte TX/RX holding registers and implements cycle, instruction and optional branch counters.

Parameters:
- MMIO_BASE, 4'h8, value of addr[31:28] that selects this block.
- CTR_WIDTH, 32, width of every performance counter; counters wrap modulo 2^CTR_WIDTH.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- mmio_en  input  1  MEM-stage access valid, already address-decoded by the core.
- mmio_we  input  4  byte write enables from s_sel; any nonzero value means store.
- mmio_addr  input  32  byte address (ALU result).
- mmio_wdata  input  32  store data.
- mmio_rdata  output  32  registered read data.
- inst_retire  input  1  pulse per retired (non-bubble) instruction.
- br_valid  input  1  conditional branch resolved this cycle.
- br_taken  input  1  that branch was taken.
- uart_tx_data  output  8  byte to UART transmitter.
- uart_tx_valid  output  1  TX holding register full.
- uart_tx_ready  input  1  UART accepts byte.
- uart_rx_data  input  8  received byte.
- uart_rx_valid  input  1  UART has a byte.
- uart_rx_ready  output  1  RX holding register empty.

Behaviour:
- Reset (rst low, async): mmio_rdata=0, tx_full=0, rx_full=0, overrun=0, all counters 0. Consequently uart_tx_valid=0 and uart_rx_ready=1.
- Access conditions: access = mmio_en && addr[31:28]==MMIO_BASE. Read = access && mmio_we==0. Write = access && mmio_we!=0. Decode uses addr[7:0]; addr[1:0] is ignored.
- Register map:
  - 0x00 R: {29'b0, overrun, rx_full, ~tx_full}.
  - 0x04 R: {24'b0, rx_byte}. Pops RX.
  - 0x08 W: tx_byte <= wdata[7:0].
  - 0x10 R: cycle_cnt.
  - 0x14 R: inst_cnt.
  - 0x18 W: any data clears all counters.
  - 0x1C R: br_cnt.
  - 0x20 R: br_taken_cnt.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Read latency: mmio_rdata is updated on the clock edge after a read is presented. With no read it holds its value. Reads are side-effect free except 0x04 and 0x00.
- TX path:
  - A write to 0x08 with tx_full=0 loads tx_byte and sets tx_full.
  - uart_tx_valid=tx_full and uart_tx_data=tx_byte.
  - On uart_tx_valid && uart_tx_ready, tx_full clears.
  - A write to 0x08 while tx_full=1 is dropped and sets overrun. This holds even if the handshake completes in the same cycle.
- RX path:
  - uart_rx_ready=~rx_full.
  - On uart_rx_valid && uart_rx_ready, rx_byte is captured and rx_full is set.
  - A read of 0x04 returns rx_byte (0 if empty) and clears rx_full next edge.
  - Capture and pop cannot coincide, because ready is low whenever full.
- Overrun: a read of 0x00 returns the current overrun value, then clears it. If a new overrun occurs in the same cycle, set wins.
- Counters:
  - cycle_cnt +1 every cycle.
  - inst_cnt +1 when inst_retire.
  - A write to 0x18 zeroes all counters on that edge; clear beats increment in the same cycle.
  - All counters wrap from all-ones to 0.
- Reset mid-operation: a pending TX byte is discarded and a held RX byte is lost. No UART handshake is asserted during reset.

Optional Feature:
- Macro MMIO_BRANCH_STATS_EN.
- When defined:
  - br_cnt +1 on br_valid.
  - br_taken_cnt +1 on br_valid && br_taken.
  - Both follow the same clear and wrap rules as the other counters.
- When undefined: the counters are not built, 0x1C/0x20 read 0, and br_valid/br_taken are ignored.

Test Plan:
- Release reset, idle 10 cycles, read 0x10 → rdata is 10 or 11 (bench fixes the exact value from the issue cycle). Read 0x00 → 0x00000001.
- Write 0x08=0x41 with uart_tx_ready=0, then write 0x08=0x42 → uart_tx_data=0x41 held valid. Read 0x00 → 0x4, then read again → 0x0. Raise ready 1 cycle → valid drops.
- Drive uart_rx_valid with 0x5A → uart_rx_ready falls next cycle. Read 0x00 → 0x3. Read 0x04 → 0x5A. Read 0x04 again → 0x0 and rx_ready=1.
- Pulse inst_retire 7 times, write 0x18 in a cycle where inst_retire=1 → subsequent read 0x14=0. Preload cycle_cnt to 0xFFFFFFFF via force → wraps to 0.
- Issue 4 br_valid pulses, 3 with br_taken → with MMIO_BRANCH_STATS_EN, 0x1C=4 and 0x20=3. Without the macro both read 0.
- Assert rst low mid-TX (tx_full=1) → uart_tx_valid=0 and mmio_rdata=0 immediately, without waiting for a clock edge.
